seq_serializer: RTL and testbench

//  Parallel-to-serial front end for the bit-serial sequence detector.
//  - Accepts WIDTH-bit words over a valid/ready handshake.
//  - Emits one bit per clock on x. The detector samples x on every clock.
//  - A one-word holding register lets back-to-back words stream with no idle gap.

---
 rtl/seq_serializer.sv | 93 +++++++++
 tb/tb_seq_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial front end with one-word holding register
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;
    logic [0:0]       state;

    logic accept;
    logic shifting;
    logic last_bit;
    logic out_bit;

    assign shifting  = (state == ST_SHIFT);
    assign last_bit  = shifting && (cnt == LAST_CNT);
    assign din_ready = !hold_full && !reset;
    assign accept    = din_valid && din_ready;

    // The output end of the shifter is fixed by bit order; shifting moves the next bit there.
    assign out_bit = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign sh_next = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};

    assign x         = (shifting && !reset) ? out_bit : IDLE_BIT;
    assign x_valid   = shifting && !reset;
    assign word_done = last_bit && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            sh        <= '0;
            cnt       <= '0;
        end else begin
            // Accept needs an empty hold and reload needs a full one, so the two
            // hold_full updates below never fire on the same edge.
            if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (hold_full) begin
                        sh        <= hold;
                        cnt       <= '0;
                        hold_full <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (hold_full) begin
                            sh        <= hold;
                            hold_full <= 1'b0;
                        end else begin
                            sh    <= sh_next;
                            state <= ST_IDLE;
                        end
                    end else begin
                        sh  <= sh_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - randomized self-checking bench with a schedule-based reference model
module tb_seq_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;

    logic m_ready, m_x, m_xv, m_wd;
    logic l_ready, l_x, l_xv, l_wd;

    int tests;
    int fails;
    int cyc;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (m_ready),
        .x         (m_x),
        .x_valid   (m_xv),
        .word_done (m_wd)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (l_ready),
        .x         (l_x),
        .x_valid   (l_xv),
        .word_done (l_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each accepted word: accept edge k, first-bit cycle s; it sits in hold for cycles k..s-1.
    typedef struct {
        int         k;
        int         s;
        logic [7:0] w;
    } ent_t;

    ent_t sched[$];
    int   last_end;

    function automatic logic model_hold_full(int c);
        foreach (sched[i])
            if (sched[i].k <= c && c < sched[i].s) return 1'b1;
        return 1'b0;
    endfunction

    // {x, x_valid, word_done, din_ready} for MSB-first then LSB-first instance.
    function automatic logic [7:0] exp_vec();
        logic ex, elx, exv, ewd, erdy;
        ex = 1'b1; elx = 1'b1; exv = 1'b0; ewd = 1'b0; erdy = 1'b0;
        if (!reset) begin
            erdy = !model_hold_full(cyc);
            foreach (sched[i]) begin
                if (sched[i].s <= cyc && cyc <= sched[i].s + 7) begin
                    ex  = sched[i].w[7 - (cyc - sched[i].s)];
                    elx = sched[i].w[cyc - sched[i].s];
                    exv = 1'b1;
                    ewd = (cyc == sched[i].s + 7);
                end
            end
        end
        return {ex, exv, ewd, erdy, elx, exv, ewd, erdy};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {m_x, m_xv, m_wd, m_ready, l_x, l_xv, l_wd, l_ready};
    endfunction

    function automatic logic model_accepts();
        return !reset && din_valid && !model_hold_full(cyc);
    endfunction

    task automatic drive(input logic r, input logic v, input logic [7:0] d);
        reset = r; din_valid = v; din = d;
        #1;
    endtask

    task automatic advance();
        int s;
        @(posedge clk);
        if (reset) begin
            sched.delete();
            last_end = -100;
        end else if (din_valid && !model_hold_full(cyc)) begin
            s = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
            sched.push_back('{k: cyc + 1, s: s, w: din});
            last_end = s + 7;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 8'hFF);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(i == 3 ? 1'b0 : 1'b1, 1'b1, 8'h3C);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (i < 3) advance();
        end
        drive(1'b1, 1'b0, 8'h00);
        advance();
    endtask

    task automatic test_single_word();
        logic [7:0] cap;
        int nvalid;
        cap = '0; nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, i == 0, i == 0 ? 8'hA5 : 8'h5A);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL single_word cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (m_xv) begin cap = {cap[6:0], m_x}; nvalid++; end
            advance();
        end
        tests++;
        if (cap !== 8'hA5 || nvalid != 8) begin
            fails++;
            $display("FAIL single_word_stream got=%h/%0d exp=a5/8", cap, nvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cap;
        int nacc, ndone, nvalid, first, lastv;
        cap = '0; nacc = 0; ndone = 0; nvalid = 0; first = -1; lastv = -1;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, nacc < 2, nacc == 0 ? 8'h05 : 8'h0A);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (m_xv) begin
                cap = {cap[14:0], m_x}; nvalid++;
                if (first < 0) first = i;
                lastv = i;
            end
            if (m_wd) ndone++;
            if (model_accepts()) nacc++;
            advance();
        end
        tests++;
        if (cap !== 16'h050A || nvalid != 16 || lastv - first != 15 || ndone != 2) begin
            fails++;
            $display("FAIL back_to_back_stream got=%h n=%0d span=%0d done=%0d exp=050a n=16 span=15 done=2",
                     cap, nvalid, lastv - first, ndone);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] cap;
        cap = '0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, i == 0, i == 0 ? 8'h01 : 8'hFE);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL lsb_first cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (l_xv) cap = {l_x, cap[7:1]};
            advance();
        end
        tests++;
        if (cap !== 8'h01) begin
            fails++;
            $display("FAIL lsb_first_stream got=%h exp=01", cap);
        end
    endtask

    task automatic test_reset_mid_word();
        int nvalid_after;
        nvalid_after = 0;
        for (int i = 0; i < 16; i++) begin
            drive(i == 5, i < 3, i == 0 ? 8'hA5 : 8'h3C);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL reset_mid_word cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (i > 5 && (m_xv || l_xv)) nvalid_after++;
            if (i == 6 && m_ready !== 1'b1) begin
                fails++;
                $display("FAIL reset_mid_word_ready got=%b exp=1", m_ready);
            end
            if (i == 6) tests++;
            advance();
        end
        tests++;
        if (nvalid_after != 0) begin
            fails++;
            $display("FAIL reset_mid_word_bits got=%0d exp=0", nvalid_after);
        end
    endtask

    task automatic test_hold_change();
        int nacc;
        nacc = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, nacc < 3, 8'($urandom));
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL hold_change cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (model_accepts()) nacc++;
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, 8'($urandom));
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            advance();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 8'h00);
            advance();
        end
    endtask

    // Overlapping 0101 detector fed from the MSB-first line; first bit is two cycles after drive.
    task automatic test_detector();
        logic [2:0] hist;
        logic z, ez;
        int p;
        hist = 3'b111;
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, i == 0, 8'h55);
            p  = i - 1;
            z  = ({hist, m_x} == 4'b0101);
            ez = (p == 4 || p == 6 || p == 8);
            tests++;
            if (z !== ez) begin
                fails++;
                $display("FAIL detector cyc=%0d bit=%0d got z=%b exp z=%b", cyc, p, z, ez);
            end
            hist = {hist[1:0], m_x};
            advance();
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; last_end = -100;
        reset = 1'b1; din_valid = 1'b0; din = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_word();
        test_hold_change();
        test_detector();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
